// File: rtl/fpu_arb_pkg.sv
// Shared types and sizing helpers for the FPU-unit arbiters (fsqrt, fdiv, finv).
package fpu_arb_pkg;
  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned TAG_W     = $clog2(N_REQ_DEF);

  typedef logic [31:0] fp32_t;

  function automatic int unsigned tag_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// In-order tag FIFO: tracks which requester owns each in-flight operation.
module tag_fifo #(
  parameter int unsigned W     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/fsqrt_arbiter.sv
// Round-robin arbiter sharing one pipelined fsqrt among N_REQ requesters;
// results are routed back in issue order using a tag FIFO.
module fsqrt_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0][31:0] req_a,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output fp32_t                  resp_data,
  output fp32_t                  sq_a,
  output logic                   sq_valid,
  input  fp32_t                  sq_result,
  input  logic                   sq_out_valid,
  output logic                   err_orphan
);
  localparam int unsigned TW = tag_width(N_REQ);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [TW-1:0]    rr_ptr, rr_next, gnt_idx, head_tag, idx;
  logic [CW-1:0]    inflight;
  logic [N_REQ-1:0] grant;
  logic             push, pop, fifo_full, fifo_empty;

  // Grant is withheld during reset and whenever every slot is in flight.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    idx     = '0;
    if (rst_n && inflight != CW'(DEPTH) && !fifo_full) begin
      for (int unsigned k = 0; k < N_REQ; k++) begin
        idx = TW'((32'(rr_ptr) + k) % N_REQ);
        if (grant == '0 && req_valid[idx]) begin
          grant[idx] = 1'b1;
          gnt_idx    = idx;
        end
      end
    end
  end

  assign req_ready = grant;
  assign push      = |grant;
  assign pop       = sq_out_valid & ~fifo_empty;
  assign rr_next   = (32'(gnt_idx) == N_REQ - 1) ? '0 : gnt_idx + TW'(1);

  tag_fifo #(
    .W     (TW),
    .DEPTH (DEPTH)
  ) u_tags (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (gnt_idx),
    .pop       (pop),
    .head      (head_tag),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      inflight   <= '0;
      sq_valid   <= 1'b0;
      sq_a       <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
      err_orphan <= 1'b0;
    end else begin
      sq_valid <= push;
      if (push) begin
        rr_ptr <= rr_next;
        sq_a   <= req_a[gnt_idx];
      end
      if (push && !pop)      inflight <= inflight + CW'(1);
      else if (!push && pop) inflight <= inflight - CW'(1);
      resp_valid <= '0;
      if (pop) begin
        resp_valid[head_tag] <= 1'b1;
        resp_data            <= sq_result;
      end
      if (sq_out_valid && fifo_empty) err_orphan <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fsqrt_arbiter.sv
// Bench for fsqrt_arbiter: two instances (DEPTH 8 and 2) each fed by a
// 3-cycle fsqrt stand-in, with a scoreboard checking routing, data and latency.
module tb_fsqrt_arbiter;
  localparam int L = 3;

  typedef struct {
    int unsigned tag;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fails  = 0;

  // DUT A (DEPTH 8) signals
  logic [3:0]       req_valid_a, req_ready_a, resp_valid_a;
  logic [3:0][31:0] req_a_a;
  logic [31:0]      resp_data_a, sq_a_a, sq_result_a;
  logic             sq_valid_a, sq_out_valid_a, err_orphan_a, force_ov;
  // DUT B (DEPTH 2) signals
  logic [3:0]       req_valid_b, req_ready_b, resp_valid_b;
  logic [3:0][31:0] req_a_b;
  logic [31:0]      resp_data_b, sq_a_b, sq_result_b;
  logic             sq_valid_b, sq_out_valid_b, err_orphan_b;

  fsqrt_arbiter #(.N_REQ(4), .DEPTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_a(req_a_a),
    .req_ready(req_ready_a), .resp_valid(resp_valid_a), .resp_data(resp_data_a),
    .sq_a(sq_a_a), .sq_valid(sq_valid_a), .sq_result(sq_result_a),
    .sq_out_valid(sq_out_valid_a), .err_orphan(err_orphan_a));

  fsqrt_arbiter #(.N_REQ(4), .DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_a(req_a_b),
    .req_ready(req_ready_b), .resp_valid(resp_valid_b), .resp_data(resp_data_b),
    .sq_a(sq_a_b), .sq_valid(sq_valid_b), .sq_result(sq_result_b),
    .sq_out_valid(sq_out_valid_b), .err_orphan(err_orphan_b));

  function automatic logic [31:0] sqrt_fn(input logic [31:0] x);
    case (x)
      32'h3F800000: return 32'h3F800000; // 1.0   -> 1.0
      32'h40800000: return 32'h40000000; // 4.0   -> 2.0
      32'h41100000: return 32'h40400000; // 9.0   -> 3.0
      32'h41800000: return 32'h40800000; // 16.0  -> 4.0
      32'h3E800000: return 32'h3F000000; // 0.25  -> 0.5
      32'h40000000: return 32'h3FB504F3; // 2.0   -> sqrt(2)
      32'h42C80000: return 32'h41200000; // 100.0 -> 10.0
      32'h00000000: return 32'h00000000; // 0.0   -> 0.0
      default:      return 32'h7FC00000;
    endcase
  endfunction

  // fsqrt stand-ins: input_valid in cycle k -> out_valid in cycle k+L
  logic [L-1:0] pv_a, pv_b;
  logic [31:0]  pd_a [L];
  logic [31:0]  pd_b [L];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_a <= '0;
      pv_b <= '0;
      for (int i = 0; i < L; i++) begin
        pd_a[i] <= '0;
        pd_b[i] <= '0;
      end
    end else begin
      pv_a    <= {pv_a[L-2:0], sq_valid_a};
      pv_b    <= {pv_b[L-2:0], sq_valid_b};
      pd_a[0] <= sqrt_fn(sq_a_a);
      pd_b[0] <= sqrt_fn(sq_a_b);
      for (int i = 1; i < L; i++) begin
        pd_a[i] <= pd_a[i-1];
        pd_b[i] <= pd_b[i-1];
      end
    end
  end
  assign sq_out_valid_a = pv_a[L-1] | force_ov;
  assign sq_result_a    = pd_a[L-1];
  assign sq_out_valid_b = pv_b[L-1];
  assign sq_result_b    = pd_b[L-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qa.delete();
    end else begin
      if (resp_valid_a != '0) begin
        if (qa.size() == 0) check("resp_unexpected_a", 32'(resp_valid_a), 32'h0);
        else begin
          e = qa.pop_front();
          check("resp_route_a", 32'(resp_valid_a), 32'(4'b0001 << e.tag));
          check("resp_data_a", resp_data_a, e.data);
          check("resp_latency_a", 32'(cyc - e.cyc), 32'(L + 2));
        end
      end
      for (int unsigned g = 0; g < 4; g++)
        if (req_valid_a[g] && req_ready_a[g]) qa.push_back('{g, sqrt_fn(req_a_a[g]), cyc});
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      qb.delete();
    end else begin
      if (resp_valid_b != '0) begin
        if (qb.size() == 0) check("resp_unexpected_b", 32'(resp_valid_b), 32'h0);
        else begin
          e = qb.pop_front();
          check("resp_route_b", 32'(resp_valid_b), 32'(4'b0001 << e.tag));
          check("resp_data_b", resp_data_b, e.data);
        end
      end
      for (int unsigned g = 0; g < 4; g++)
        if (req_valid_b[g] && req_ready_b[g]) qb.push_back('{g, sqrt_fn(req_a_b[g]), cyc});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit use_b);
    for (int i = 0; i < 40 && (use_b ? qb.size() : qa.size()) != 0; i++) step();
    if (use_b) check("drain_b", 32'(qb.size()), 32'h0);
    else       check("drain_a", 32'(qa.size()), 32'h0);
  endtask

  initial begin
    int          t0;
    bit          found;
    logic [5:0]  sat_exp;
    logic [31:0] ops [4];
    ops     = '{32'h3E800000, 32'h40000000, 32'h42C80000, 32'h00000000};
    sat_exp = 6'b100011;

    rst_n       = 1'b0;
    force_ov    = 1'b0;
    req_valid_a = 4'hF;
    req_valid_b = 4'hF;
    req_a_a     = '0;
    req_a_b     = '0;
    #12;
    check("rst_ready_a", 32'(req_ready_a), 32'h0);
    check("rst_ready_b", 32'(req_ready_b), 32'h0);
    check("rst_resp_valid", 32'(resp_valid_a), 32'h0);
    check("rst_resp_data", resp_data_a, 32'h0);
    check("rst_sq_valid", 32'(sq_valid_a), 32'h0);
    check("rst_sq_a", sq_a_a, 32'h0);
    check("rst_orphan", 32'(err_orphan_a), 32'h0);
    req_valid_a = '0;
    req_valid_b = '0;
    step();
    rst_n = 1'b1;

    // Single request from requester 2
    req_a_a[2]  = 32'h40800000;
    req_valid_a = 4'b0100;
    @(negedge clk);
    check("single_grant", 32'(req_ready_a), 32'h4);
    t0 = cyc;
    step();
    req_valid_a = '0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (resp_valid_a != '0) found = 1'b1;
    end
    check("single_seen", 32'(found), 32'h1);
    check("single_route", 32'(resp_valid_a), 32'h4);
    check("single_data", resp_data_a, 32'h40000000);
    check("single_latency", 32'(cyc - t0), 32'(L + 2));
    step();

    // All four requesters continuously valid
    apply_reset();
    req_a_a     = {32'h41800000, 32'h41100000, 32'h40800000, 32'h3F800000};
    req_valid_a = 4'hF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rr_grant", 32'(req_ready_a), 32'(4'b0001 << (k % 4)));
      step();
    end
    req_valid_a = '0;
    drain(1'b0);

    // Saturation on the DEPTH=2 instance
    req_a_b[0]  = 32'h41100000;
    req_a_b[1]  = 32'h41800000;
    req_valid_b = 4'b0011;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("sat_ready", 32'(|req_ready_b), 32'(sat_exp[k]));
      if (k == 4) check("sat_first_ov", 32'(sq_out_valid_b), 32'h1);
      step();
    end
    req_valid_b = '0;
    drain(1'b1);

    // Requester 1 alone, back-to-back
    req_valid_a = 4'b0010;
    for (int k = 0; k < 10; k++) begin
      req_a_a[1] = ops[k % 4];
      @(negedge clk);
      check("r1_grant", 32'(req_ready_a), 32'h2);
      step();
    end
    req_valid_a = '0;
    drain(1'b0);
    check("r1_last_data", resp_data_a, 32'h3FB504F3);

    // Reset with three operations in flight
    req_a_a     = {32'h0, 32'h41100000, 32'h40800000, 32'h3F800000};
    req_valid_a = 4'b0111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("pre_rst_grant", 32'(|req_ready_a), 32'h1);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 32'(req_ready_a), 32'h0);
    check("midrst_resp_valid", 32'(resp_valid_a), 32'h0);
    check("midrst_resp_data", resp_data_a, 32'h0);
    check("midrst_sq_valid", 32'(sq_valid_a), 32'h0);
    check("midrst_sq_a", sq_a_a, 32'h0);
    check("midrst_orphan", 32'(err_orphan_a), 32'h0);
    req_valid_a = '0;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_quiet", 32'(resp_valid_a), 32'h0);
      step();
    end

    // Orphan result with empty FIFO
    force_ov = 1'b1;
    step();
    force_ov = 1'b0;
    @(negedge clk);
    check("orphan_set", 32'(err_orphan_a), 32'h1);
    check("orphan_no_resp", 32'(resp_valid_a), 32'h0);
    repeat (3) step();
    @(negedge clk);
    check("orphan_sticky", 32'(err_orphan_a), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
